// File: rtl/lot_occupancy_multi_if.sv
// Sensor/status bundle for lot_occupancy_multi.
// The peak output exists only when PEAK_TRACK_EN is defined.
interface lot_occupancy_multi_if #(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 16
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic [NUM_GATES-1:0] sens_a;
  logic [NUM_GATES-1:0] sens_b;
  logic                 clr_err;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic [NUM_GATES-1:0] enter_pulse;
  logic [NUM_GATES-1:0] exit_pulse;
  logic                 ovf;
  logic                 unf;
`ifdef PEAK_TRACK_EN
  logic [CW-1:0]        peak;

  modport master (output sens_a, sens_b, clr_err,
                  input  count, full, empty, enter_pulse, exit_pulse, ovf, unf, peak);
  modport slave  (input  sens_a, sens_b, clr_err,
                  output count, full, empty, enter_pulse, exit_pulse, ovf, unf, peak);
`else
  modport master (output sens_a, sens_b, clr_err,
                  input  count, full, empty, enter_pulse, exit_pulse, ovf, unf);
  modport slave  (input  sens_a, sens_b, clr_err,
                  output count, full, empty, enter_pulse, exit_pulse, ovf, unf);
`endif
endinterface

// File: rtl/lot_occupancy_multi.sv
// Multi-gate parking-lot occupancy counter: per-gate direction FSMs feed one
// saturating count with sticky ovf/unf. Optional peak tracking: PEAK_TRACK_EN.
module lot_gate_fsm (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_ev,
  output logic exit_ev,
  output logic enter_pulse,
  output logic exit_pulse
);
  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} state_t;
  state_t state;
  logic [1:0] ab;

  assign ab = {a, b};
  // Same-cycle event strobes let the count move on the very edge that samples 00.
  assign enter_ev = (state == IN3)  && (ab == 2'b00);
  assign exit_ev  = (state == OUT3) && (ab == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      enter_pulse <= enter_ev;
      exit_pulse  <= exit_ev;
      case (state)
        IDLE: if (ab == 2'b10) state <= IN1;
              else if (ab == 2'b01) state <= OUT1;
        IN1:  if (ab == 2'b11) state <= IN2;
              else if (ab != 2'b10) state <= IDLE;
        IN2:  case (ab)
                2'b01:   state <= IN3;
                2'b10:   state <= IN1;
                2'b00:   state <= IDLE;
                default: state <= IN2;
              endcase
        IN3:  case (ab)
                2'b11:   state <= IN2;
                2'b01:   state <= IN3;
                default: state <= IDLE;
              endcase
        OUT1: if (ab == 2'b11) state <= OUT2;
              else if (ab != 2'b01) state <= IDLE;
        OUT2: case (ab)
                2'b10:   state <= OUT3;
                2'b01:   state <= OUT1;
                2'b00:   state <= IDLE;
                default: state <= OUT2;
              endcase
        OUT3: case (ab)
                2'b11:   state <= OUT2;
                2'b10:   state <= OUT3;
                default: state <= IDLE;
              endcase
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module lot_occupancy_multi #(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  lot_occupancy_multi_if.slave  bus
);
  localparam int CW = $clog2(CAPACITY + 1);
  // Headroom so count + NUM_GATES never wraps even for tiny CAPACITY.
  localparam int NW = CW + 5;
  localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);

  logic [NUM_GATES-1:0] enter_ev, exit_ev, enter_q, exit_q;
  logic [CW-1:0]        count_q, cnext;
  logic signed [NW-1:0] n_ent, n_ext, nxt;
  logic                 clamp_hi, clamp_lo, ovf_q, unf_q;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    lot_gate_fsm u_gate (
      .clk         (clk),
      .reset       (reset),
      .a           (bus.sens_a[g]),
      .b           (bus.sens_b[g]),
      .enter_ev    (enter_ev[g]),
      .exit_ev     (exit_ev[g]),
      .enter_pulse (enter_q[g]),
      .exit_pulse  (exit_q[g])
    );
  end

  always_comb begin
    n_ent = '0;
    n_ext = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      n_ent = n_ent + NW'(enter_ev[g]);
      n_ext = n_ext + NW'(exit_ev[g]);
    end
    nxt      = $signed({{(NW-CW){1'b0}}, count_q}) + n_ent - n_ext;
    clamp_hi = nxt > CAP_S;
    clamp_lo = nxt < 0;
    if (clamp_hi)      cnext = CW'(CAPACITY);
    else if (clamp_lo) cnext = '0;
    else               cnext = nxt[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= cnext;
      // A fresh clamp outranks a simultaneous clear.
      if (clamp_hi)         ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
      if (clamp_lo)         unf_q <= 1'b1;
      else if (bus.clr_err) unf_q <= 1'b0;
    end
  end

`ifdef PEAK_TRACK_EN
  logic [CW-1:0] peak_q;
  always_ff @(posedge clk) begin
    if (reset)                peak_q <= '0;
    else if (bus.clr_err)     peak_q <= cnext;
    else if (cnext > peak_q)  peak_q <= cnext;
  end
  assign bus.peak = peak_q;
`endif

  assign bus.count       = count_q;
  assign bus.full        = (count_q == CW'(CAPACITY));
  assign bus.empty       = (count_q == '0);
  assign bus.enter_pulse = enter_q;
  assign bus.exit_pulse  = exit_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule

// File: tb/tb_lot_occupancy_multi.sv
// Directed plus randomized bench for lot_occupancy_multi against a positional
// passage model (progress index along the entry/exit sensor path).
module tb_lot_occupancy_multi;
  localparam int NG  = 2;
  localparam int CAP = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lot_occupancy_multi_if #(.NUM_GATES(NG), .CAPACITY(CAP)) bus ();
  lot_occupancy_multi #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vecs = 0;
  int errs = 0;

  // Model: dir +1 = heading in, -1 = heading out, 0 = idle; pos = 1..3 along the path.
  int       m_dir [NG];
  int       m_pos [NG];
  int       m_count;
  int       m_peak;
  logic     m_ovf, m_unf;
  logic [NG-1:0] m_ent, m_ext;
  logic [1:0] scr [NG][$];

  function automatic int path_idx(int dir, logic [1:0] s);
    if (dir == 1)  return (s == 2'b10) ? 1 : (s == 2'b11) ? 2 : (s == 2'b01) ? 3 : 0;
    if (dir == -1) return (s == 2'b01) ? 1 : (s == 2'b11) ? 2 : (s == 2'b10) ? 3 : 0;
    return 0;
  endfunction

  task automatic model(input logic [1:0] s0, input logic [1:0] s1, input logic clr, input logic rst);
    logic [1:0] s;
    int p, nx;
    m_ent = '0;
    m_ext = '0;
    if (rst) begin
      for (int g = 0; g < NG; g++) begin m_dir[g] = 0; m_pos[g] = 0; end
      m_count = 0; m_peak = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    for (int g = 0; g < NG; g++) begin
      s = (g == 0) ? s0 : s1;
      if (m_dir[g] == 0) begin
        if (s == 2'b10) begin m_dir[g] = 1;  m_pos[g] = 1; end
        else if (s == 2'b01) begin m_dir[g] = -1; m_pos[g] = 1; end
      end else if (s == 2'b00) begin
        if (m_pos[g] == 3) begin
          if (m_dir[g] == 1) m_ent[g] = 1'b1; else m_ext[g] = 1'b1;
        end
        m_dir[g] = 0;
      end else begin
        p = path_idx(m_dir[g], s);
        if (p - m_pos[g] <= 1 && m_pos[g] - p <= 1) m_pos[g] = p;
        else m_dir[g] = 0;
      end
    end
    nx = m_count + $countones(m_ent) - $countones(m_ext);
    if (nx > CAP)    begin nx = CAP; m_ovf = 1; end
    else if (clr)    m_ovf = 0;
    if (nx < 0)      begin nx = 0; m_unf = 1; end
    else if (clr)    m_unf = 0;
    m_count = nx;
    if (clr) m_peak = nx;
    else if (nx > m_peak) m_peak = nx;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step2(input logic [1:0] s0, input logic [1:0] s1, input logic clr, input logic rst);
    @(negedge clk);
    bus.sens_a  = {s1[1], s0[1]};
    bus.sens_b  = {s1[0], s0[0]};
    bus.clr_err = clr;
    reset       = rst;
    @(posedge clk);
    #1;
    model(s0, s1, clr, rst);
    chk("count",       32'(bus.count),       32'(m_count));
    chk("full",        32'(bus.full),        32'(m_count == CAP));
    chk("empty",       32'(bus.empty),       32'(m_count == 0));
    chk("enter_pulse", 32'(bus.enter_pulse), 32'(m_ent));
    chk("exit_pulse",  32'(bus.exit_pulse),  32'(m_ext));
    chk("ovf",         32'(bus.ovf),         32'(m_ovf));
    chk("unf",         32'(bus.unf),         32'(m_unf));
`ifdef PEAK_TRACK_EN
    chk("peak",        32'(bus.peak),        32'(m_peak));
`endif
  endtask

  function automatic logic [1:0] pat(int k, int i);
    logic [1:0] ent [4];
    logic [1:0] ext [4];
    ent = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext = '{2'b01, 2'b11, 2'b10, 2'b00};
    if (k == 1) return ent[i];
    if (k == 2) return ext[i];
    return 2'b00;
  endfunction

  // k: 0 idle, 1 entry, 2 exit; all four samples applied in lockstep.
  task automatic pass(input int k0, input int k1);
    for (int i = 0; i < 4; i++) step2(pat(k0, i), pat(k1, i), 1'b0, 1'b0);
  endtask

  task automatic fill(input int g, input bit bias_in);
    int r, k;
    r = $urandom_range(0, 5);
    if (r <= 2)       k = bias_in ? 1 : 2;
    else if (r == 3)  k = bias_in ? 2 : 1;
    else              k = r - 1;
    if (k <= 2) begin
      for (int i = 0; i < 4; i++)
        repeat ((i == 3) ? 1 : 1 + $urandom_range(0, 1)) scr[g].push_back(pat(k, i));
    end else if (k == 3) begin
      scr[g].push_back(2'b10); scr[g].push_back(2'b11);
      scr[g].push_back(2'b10); scr[g].push_back(2'b00);
    end else begin
      repeat (3) scr[g].push_back(2'($urandom_range(0, 3)));
      scr[g].push_back(2'b00);
    end
  endtask

  initial begin
    logic [1:0] r0, r1;
    bus.sens_a = '0; bus.sens_b = '0; bus.clr_err = 1'b0;

    step2(2'b00, 2'b00, 1'b0, 1'b1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);

    pass(1, 0);
    chk("entry_pulse", 32'(bus.enter_pulse), 32'b01);
    chk("entry_count", 32'(bus.count), 32'd1);
    chk("entry_empty", 32'(bus.empty), 32'd0);
    step2(2'b00, 2'b00, 1'b0, 1'b0);
    chk("entry_pulse_one", 32'(bus.enter_pulse), 32'b00);

    pass(1, 0); pass(1, 0);
    pass(0, 2);
    chk("exit_pulse", 32'(bus.exit_pulse), 32'b10);
    chk("exit_count", 32'(bus.count), 32'd2);

    step2(2'b10, 2'b00, 1'b0, 1'b0);
    step2(2'b11, 2'b00, 1'b0, 1'b0);
    step2(2'b10, 2'b00, 1'b0, 1'b0);
    step2(2'b00, 2'b00, 1'b0, 1'b0);
    chk("backout_pulse", 32'(bus.enter_pulse), 32'b00);
    chk("backout_count", 32'(bus.count), 32'd2);

    pass(1, 0); pass(1, 0); pass(1, 0);
    pass(1, 2);
    chk("simul_ent", 32'(bus.enter_pulse), 32'b01);
    chk("simul_ext", 32'(bus.exit_pulse), 32'b10);
    chk("simul_count", 32'(bus.count), 32'd5);

    repeat (5) pass(1, 1);
    pass(1, 0);
    chk("at_cap", 32'(bus.count), 32'd16);
    pass(1, 1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    step2(2'b00, 2'b00, 1'b1, 1'b0);
    chk("ovf_clr", 32'(bus.ovf), 32'd0);

    step2(2'b00, 2'b00, 1'b0, 1'b1);
    pass(0, 2);
    chk("unf_count", 32'(bus.count), 32'd0);
    chk("unf_set", 32'(bus.unf), 32'd1);

    step2(2'b10, 2'b00, 1'b0, 1'b0);
    step2(2'b11, 2'b00, 1'b0, 1'b0);
    step2(2'b11, 2'b00, 1'b0, 1'b1);
    chk("midrst_unf", 32'(bus.unf), 32'd0);
    step2(2'b01, 2'b00, 1'b0, 1'b0);
    step2(2'b00, 2'b00, 1'b0, 1'b0);
    chk("midrst_nopulse", 32'({bus.enter_pulse, bus.exit_pulse}), 32'd0);
    chk("midrst_count", 32'(bus.count), 32'd0);

    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < NG; g++) if (scr[g].size() == 0) fill(g, (c % 200) < 100);
      r0 = scr[0].pop_front();
      r1 = scr[1].pop_front();
      step2(r0, r1, ($urandom_range(0, 29) == 0), ($urandom_range(0, 249) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
